// File: rtl/serial_frame_rx_ctrl_if.sv
// Consumer-side data handshake for serial_frame_rx_ctrl.
//   data  : captured frame word (source -> sink)
//   valid : data valid, held until accepted (source -> sink)
//   ready : sink accepts data (sink -> source)
// Modports: master = frame controller (source), slave = consumer (sink).
interface serial_frame_rx_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/serial_frame_rx_ctrl.sv
// Frame-level sequencer for a serial-to-parallel deserializer.
// Accepts a frame request, latches the frame size, clears the deserializer,
// enables shifting until it reports complete, then hands the parallel word
// to the consumer over a valid/ready handshake.
//
// Ports:
//   clk, rst            single clock (posedge), synchronous active-high reset
//   i_start             request one frame (level, sampled in IDLE/HOLD)
//   i_abort             cancel current frame, return to IDLE
//   i_frame_size        bits per frame, latched on an accepted start
//   o_stp_reset         sync clear to deserializer and its bit counter
//   o_stp_enable        shift enable to deserializer
//   o_stp_frame_size    latched frame size for the deserializer
//   i_stp_complete      deserializer complete flag
//   i_stp_parallel      deserializer parallel word
//   m_data              consumer handshake (data/valid out, ready in)
//   o_busy              high in every state except IDLE
//   o_frame_count       delivered frames, wraps to 0
//   o_error             one-cycle pulse on SHIFT timeout
//
// Optional feature macro: FRAME_TIMEOUT_EN
//   defined   : SHIFT is bounded to TIMEOUT cycles, then ERR pulses o_error
//   undefined : no timeout counter, SHIFT waits indefinitely, o_error = 0
module serial_frame_rx_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [WIDTH-1:0]       i_frame_size,
  output logic                   o_stp_reset,
  output logic                   o_stp_enable,
  output logic [WIDTH-1:0]       o_stp_frame_size,
  input  logic                   i_stp_complete,
  input  logic [WIDTH-1:0]       i_stp_parallel,
  serial_frame_rx_ctrl_if.master m_data,
  output logic                   o_busy,
  output logic [CNT_W-1:0]       o_frame_count,
  output logic                   o_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_HOLD,
    ST_ERR
  } state_t;

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("serial_frame_rx_ctrl: TIMEOUT must be at least 1");
  end

  state_t           r_state;
  state_t           w_next;
  logic             r_first;
  logic             r_stp_reset;
  logic             r_stp_enable;
  logic [WIDTH-1:0] r_size;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;

  logic             w_latch;
  logic             w_count_inc;
  logic             w_abort;
  logic             w_timeout;
  logic             w_start_ok;

  logic             w_stp_reset_nxt;
  logic             w_stp_enable_nxt;
  logic [WIDTH-1:0] w_size_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic [CNT_W-1:0] w_count_nxt;

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_error;

  // Cycle count within SHIFT; zero in the first SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_SHIFT)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else begin
      r_error <= (w_next == ST_ERR);
    end
  end

  assign o_error = r_error;
`else
  assign w_timeout = 1'b0;
  assign o_error   = 1'b0;
`endif

  assign w_start_ok = i_start && (i_frame_size != '0);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_first      <= 1'b0;
      r_stp_reset  <= 1'b1;
      r_stp_enable <= 1'b0;
      r_size       <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state      <= w_next;
      // Marks the first SHIFT cycle, where a stale complete flag is ignored.
      r_first      <= (r_state != ST_SHIFT);
      r_stp_reset  <= w_stp_reset_nxt;
      r_stp_enable <= w_stp_enable_nxt;
      r_size       <= w_size_nxt;
      r_data       <= w_data_nxt;
      r_valid      <= w_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_count      <= w_count_nxt;
    end
  end

  // Next state
  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_count_inc = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_next  = ST_CLEAR;
          w_latch = 1'b1;
        end
      end
      ST_CLEAR: w_next = ST_SHIFT;
      ST_SHIFT: begin
        if (!r_first && i_stp_complete) begin
          w_next = ST_HOLD;
        end else if (w_timeout) begin
          w_next = ST_ERR;
        end
      end
      ST_HOLD: begin
        if (m_data.ready) begin
          w_count_inc = 1'b1;
          if (w_start_ok) begin
            w_next  = ST_CLEAR;
            w_latch = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    // Abort overrides every other decision outside IDLE.
    if ((r_state != ST_IDLE) && i_abort) begin
      w_next      = ST_IDLE;
      w_latch     = 1'b0;
      w_count_inc = 1'b0;
      w_abort     = 1'b1;
    end
  end

  // Outputs are a function of the upcoming state, registered above.
  always_comb begin
    w_stp_reset_nxt  = (w_next == ST_CLEAR) || (w_next == ST_ERR) || w_abort;
    w_stp_enable_nxt = (w_next == ST_SHIFT);
    w_valid_nxt      = (w_next == ST_HOLD);
    w_busy_nxt       = (w_next != ST_IDLE);
    w_size_nxt       = w_latch ? i_frame_size : r_size;
    w_data_nxt       = ((r_state == ST_SHIFT) && (w_next == ST_HOLD)) ? i_stp_parallel : r_data;
    w_count_nxt      = w_count_inc ? (r_count + CNT_W'(1)) : r_count;
  end

  assign o_stp_reset      = r_stp_reset;
  assign o_stp_enable     = r_stp_enable;
  assign o_stp_frame_size = r_size;
  assign m_data.data      = r_data;
  assign m_data.valid     = r_valid;
  assign o_busy           = r_busy;
  assign o_frame_count    = r_count;

endmodule

// File: tb/tb_serial_frame_rx_ctrl.sv
module tb_serial_frame_rx_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  frame_size;
  logic        stp_reset;
  logic        stp_enable;
  logic [7:0]  stp_frame_size;
  logic        stp_complete;
  logic [7:0]  stp_parallel;
  logic        busy;
  logic [15:0] frame_count;
  logic        error;

  serial_frame_rx_ctrl_if #(.WIDTH(8)) u_if ();

  serial_frame_rx_ctrl #(
    .WIDTH  (8),
    .CNT_W  (16),
    .TIMEOUT(20)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (start),
    .i_abort         (abort),
    .i_frame_size    (frame_size),
    .o_stp_reset     (stp_reset),
    .o_stp_enable    (stp_enable),
    .o_stp_frame_size(stp_frame_size),
    .i_stp_complete  (stp_complete),
    .i_stp_parallel  (stp_parallel),
    .m_data          (u_if),
    .o_busy          (busy),
    .o_frame_count   (frame_count),
    .o_error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Deserializer model: MSB-first shift of tx_pattern, complete when size bits taken.
  logic [7:0] tx_pattern;
  logic [7:0] ds_shreg;
  logic [7:0] ds_cnt;
  logic       ds_stall;

  always @(posedge clk) begin
    if (stp_reset) begin
      ds_shreg <= '0;
      ds_cnt   <= '0;
    end else if (stp_enable && (ds_cnt < stp_frame_size)) begin
      ds_shreg <= {ds_shreg[6:0], tx_pattern[3'(7 - ds_cnt)]};
      ds_cnt   <= ds_cnt + 8'd1;
    end
  end

  assign stp_complete = !ds_stall && (stp_frame_size != 8'd0) && (ds_cnt == stp_frame_size);
  assign stp_parallel = ds_shreg;

  int         checks;
  int         failures;
  int         en_cycles;
  int         v_cycles;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares every accepted word against the queue.
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (!rst) begin
      if (stp_enable) en_cycles++;
      if (u_if.valid) v_cycles++;
      if (u_if.valid && u_if.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected got=%0h exp=none at %0t", u_if.data, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", {24'd0, u_if.data}, {24'd0, e});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60 && !u_if.valid; i++) step();
    check("valid_seen", {31'd0, u_if.valid}, 32'd1);
  endtask

  // Start at cycle N; returns in cycle N+1 (CLEAR).
  task automatic start_frame(input logic [7:0] sz);
    start      = 1'b1;
    frame_size = sz;
    step();
    start = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; en_cycles = 0; v_cycles = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; frame_size = 8'd0;
    tx_pattern = 8'd0; ds_stall = 1'b0; u_if.ready = 1'b0;

    // 1: reset
    repeat (3) step();
    check("rst_stp_reset", {31'd0, stp_reset}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, u_if.valid}, 32'd0);
    check("rst_enable", {31'd0, stp_enable}, 32'd0);
    check("rst_count", {16'd0, frame_count}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_stp_reset", {31'd0, stp_reset}, 32'd0);

    // 2: one frame 10110010, consumer always ready
    tx_pattern = 8'b1011_0010;
    exp_q.push_back(8'hB2);
    u_if.ready = 1'b1;
    en_cycles = 0; v_cycles = 0;
    start_frame(8'd8);
    check("clr_stp_reset", {31'd0, stp_reset}, 32'd1);
    check("clr_enable", {31'd0, stp_enable}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd1);
    check("clr_fsize", {24'd0, stp_frame_size}, 32'd8);
    step();
    check("shift_enable", {31'd0, stp_enable}, 32'd1);
    check("shift_stp_reset", {31'd0, stp_reset}, 32'd0);
    wait_valid();
    check("f1_data", {24'd0, u_if.data}, 32'hB2);
    check("f1_enable_off", {31'd0, stp_enable}, 32'd0);
    step();
    check("f1_valid_drop", {31'd0, u_if.valid}, 32'd0);
    check("f1_count", {16'd0, frame_count}, 32'd1);
    check("f1_busy", {31'd0, busy}, 32'd0);
    check("f1_en_cycles_ge8", {31'd0, (en_cycles >= 8)}, 32'd1);
    check("f1_valid_cycles", en_cycles > 0 ? v_cycles : -1, 32'd1);

    // 3: consumer stalls 5 cycles, then accepts with a back-to-back start
    tx_pattern = 8'h5C;
    exp_q.push_back(8'h5C);
    u_if.ready = 1'b0;
    start_frame(8'd8);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", {31'd0, u_if.valid}, 32'd1);
      check("hold_data", {24'd0, u_if.data}, 32'h5C);
    end
    check("hold_count", {16'd0, frame_count}, 32'd1);
    tx_pattern = 8'hE7;
    exp_q.push_back(8'hE7);
    u_if.ready = 1'b1;
    start = 1'b1;
    frame_size = 8'd8;
    step();
    start = 1'b0;
    check("b2b_stp_reset", {31'd0, stp_reset}, 32'd1);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_valid", {31'd0, u_if.valid}, 32'd0);
    check("b2b_count", {16'd0, frame_count}, 32'd2);
    wait_valid();
    step();
    check("f3_count", {16'd0, frame_count}, 32'd3);

    // 4: zero-size request is ignored
    start = 1'b1;
    frame_size = 8'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("zsz_busy", {31'd0, busy}, 32'd0);
      check("zsz_stp_reset", {31'd0, stp_reset}, 32'd0);
    end
    start = 1'b0;

    // 5: abort in the 4th SHIFT cycle
    tx_pattern = 8'hFF;
    start_frame(8'd8);
    step(); step(); step(); step();
    check("ab_enable_pre", {31'd0, stp_enable}, 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_stp_reset", {31'd0, stp_reset}, 32'd1);
    check("ab_enable", {31'd0, stp_enable}, 32'd0);
    check("ab_valid", {31'd0, u_if.valid}, 32'd0);
    step();
    check("ab_stp_reset_end", {31'd0, stp_reset}, 32'd0);
    check("ab_count", {16'd0, frame_count}, 32'd3);

    // 6: deserializer never completes
    ds_stall = 1'b1;
    start_frame(8'd8);
    step();
`ifdef FRAME_TIMEOUT_EN
    for (int i = 1; i < 20; i++) begin
      step();
      check("to_no_error", {31'd0, error}, 32'd0);
    end
    step();
    check("to_error", {31'd0, error}, 32'd1);
    check("to_stp_reset", {31'd0, stp_reset}, 32'd1);
    check("to_enable", {31'd0, stp_enable}, 32'd0);
    step();
    check("to_error_end", {31'd0, error}, 32'd0);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_count", {16'd0, frame_count}, 32'd3);
`else
    repeat (40) step();
    check("nto_busy", {31'd0, busy}, 32'd1);
    check("nto_enable", {31'd0, stp_enable}, 32'd1);
    check("nto_error", {31'd0, error}, 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("nto_abort_busy", {31'd0, busy}, 32'd0);
`endif
    ds_stall = 1'b0;

    // Reset in the middle of a frame
    tx_pattern = 8'h3C;
    start_frame(8'd8);
    step(); step();
    rst = 1'b1;
    step();
    check("mrst_stp_reset", {31'd0, stp_reset}, 32'd1);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_enable", {31'd0, stp_enable}, 32'd0);
    check("mrst_count", {16'd0, frame_count}, 32'd0);
    check("mrst_fsize", {24'd0, stp_frame_size}, 32'd0);
    rst = 1'b0;
    step();
    check("mrst_idle_reset", {31'd0, stp_reset}, 32'd0);

    step();
    check("sb_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
